q_update_engine: RTL
====================

// Module: q_update_engine
// PURPOSE
// - Q-learning write-back stage; sits downstream of the max-Q/reward stage and owns the Q-table.
// - Applies Q(s,a) += alpha*(r + gamma*maxQ' - Q(s,a)) using shift-based alpha and gamma, then writes the entry back.
// - Table is exported combinationally; the max-Q stage reads it as its old_Q input.
// PARAMETERS
// - N_STATES     37  maze states; state index range is 0..N_STATES-1
// - N_ACTIONS    4   actions per state; action index range is 0..N_ACTIONS-1
// - Q_W          32  Q-value width, unsigned
// - ALPHA_SHIFT  1   alpha = 2^-ALPHA_SHIFT
// - GAMMA_SHIFT  3   gamma = 1 - 2^-GAMMA_SHIFT
// PORTS
// - clk         in   1      clock, rising edge
// - rst         in   1      asynchronous reset, active-low
// - start       in   1      update request; sampled only in IDLE
// - prev_state  in   6      state s whose entry is updated
// - prev_action in   4      action a taken from s
// - reward      in   4      unsigned reward r
// - max_Q       in   Q_W    max Q of the next state (from max-Q stage)
// - is_terminal in   1      next state is terminal; ignored unless QUPD_TERMINAL_EN
// - busy        out  1      high in LOAD, CALC and WRITE
// - done        out  1      one-cycle pulse when an update retires
// - err         out  1      one-cycle pulse, coincident with done, on bad index
// - q_table     out  Q_W x [N_STATES][N_ACTIONS]  current table contents
// BEHAVIOUR
// - Reset (rst=0, async): every table entry = 0; busy=0, done=0, err=0; FSM=IDLE.
// - FSM: IDLE -> LOAD -> CALC -> WRITE -> IDLE; every state after IDLE lasts one cycle.
// - IDLE: when start=1, latch prev_state, prev_action, reward, max_Q and is_terminal; go to LOAD.
// - LOAD: read q_old = table[s][a]. If s>=N_STATES or a>=N_ACTIONS, set the bad flag (q_old is don't-care).
// - CALC: compute and register
//     target = r + max_Q - (max_Q >> GAMMA_SHIFT)   (Q_W+2 bits, unsigned)
//     delta  = target - q_old                       (Q_W+2 bits, signed)
// - WRITE: compute q_new = q_old + (delta >>> ALPHA_SHIFT).
//     Arithmetic shift rounds toward -inf.
//     Saturate q_new to [0, 2^Q_W-1].
//     Write q_new to table[s][a] unless the bad flag is set.
//     done=1 this cycle; err=1 if the bad flag is set.
//     On a bad index the table is not written.
// - Latency: start sampled at edge N gives done high in the cycle after edge N+3.
// - The table write is visible on q_table in the same cycle done=1.
// - start while busy: ignored, not queued.
// - start high in the WRITE cycle: ignored. The FSM returns to IDLE and samples start on the next edge.
// - Inputs are latched once in IDLE; input changes during busy do not affect the update.
// - rst asserted mid-update: the update is aborted and the table is cleared.
// - Only table[s][a] changes per update; all other entries hold.
// CONFIGURATION
// - QUPD_TERMINAL_EN defined: when the latched is_terminal=1, target = r (no bootstrap term).
//   All other behaviour is unchanged.
// - QUPD_TERMINAL_EN undefined: is_terminal is ignored and the target always includes the gamma*max_Q term.
// TESTING (ALPHA_SHIFT=1, GAMMA_SHIFT=3)
// - reset; start s=35,a=1,r=10,max_Q=0 -> done after 3 cycles, err=0, q_table[35][1]=5, all other entries 0.
// - Repeat the same request -> q_table[35][1]=7 (target 10, delta 5, +2).
// - s=5,a=2,r=0,max_Q=80 -> target 70, q_table[5][2]=35.
//   Then s=5,a=2,r=0,max_Q=0 -> delta -35, q_table[5][2]=35-18=17.
// - s=37,a=0 -> done and err pulse together, no table change.
//   s=3,a=4 -> same result.
// - start pulsed every cycle during busy -> exactly one update per IDLE visit.
//   rst low during CALC -> busy=0 and table all 0.
// - QUPD_TERMINAL_EN defined: s=30,a=0,r=10,max_Q=800,is_terminal=1 -> q_table[30][0]=5.
//   Same request without the macro -> target 710, q_table[30][0]=355.

Source files
------------

// File: rtl/q_update_engine_if.sv
// Handshake and table-export bundle for the Q-learning write-back stage.
// The master drives the update request; the slave owns and exports the table.
interface q_update_engine_if #(
  parameter int N_STATES  = 37,
  parameter int N_ACTIONS = 4,
  parameter int Q_W       = 32
);
  logic           start;
  logic [5:0]     prev_state;
  logic [3:0]     prev_action;
  logic [3:0]     reward;
  logic [Q_W-1:0] max_Q;
  logic           is_terminal;
  logic           busy;
  logic           done;
  logic           err;
  logic [Q_W-1:0] q_table [N_STATES][N_ACTIONS];

  modport master (
    output start, prev_state, prev_action,
    output reward, max_Q, is_terminal,
    input  busy, done, err, q_table
  );

  modport slave (
    input  start, prev_state, prev_action,
    input  reward, max_Q, is_terminal,
    output busy, done, err, q_table
  );
endinterface

// File: rtl/q_update_engine.sv
// Q-learning write-back stage: Q += alpha*(r + gamma*maxQ' - Q), table owner.
// Optional QUPD_TERMINAL_EN: a latched is_terminal drops the bootstrap term.
module q_update_engine #(
  parameter int N_STATES    = 37,
  parameter int N_ACTIONS   = 4,
  parameter int Q_W         = 32,
  parameter int ALPHA_SHIFT = 1,
  parameter int GAMMA_SHIFT = 3
) (
  input logic clk,
  input logic rst,
  q_update_engine_if.slave bus
);

  localparam int SW = $clog2(N_STATES);
  localparam int AW = $clog2(N_ACTIONS);
  localparam int TW = Q_W + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] CALC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  typedef logic [Q_W-1:0] tbl_t [N_STATES][N_ACTIONS];

  logic [1:0]     st_q, st_d;
  logic [5:0]     s_q, s_d;
  logic [3:0]     a_q, a_d;
  logic [3:0]     r_q, r_d;
  logic [Q_W-1:0] mq_q, mq_d;
  logic [Q_W-1:0] qold_q, qold_d;
  logic           bad_q, bad_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic signed [TW-1:0] dlt_q, dlt_d;
  tbl_t           tbl_q, tbl_d;

  logic [SW-1:0]  si;
  logic [AW-1:0]  ai;
  logic           bad_idx;
  logic [TW-1:0]  boot;
  logic [TW-1:0]  tgt;
  logic signed [TW-1:0] dsh;
  logic signed [TW:0]   qsum;
  logic [Q_W-1:0] q_new;

`ifdef QUPD_TERMINAL_EN
  logic term_q, term_d;
`else
  logic unused_term;
  assign unused_term = bus.is_terminal;
`endif

  assign si = s_q[SW-1:0];
  assign ai = a_q[AW-1:0];
  assign bad_idx = (int'(s_q) >= N_STATES) ||
                   (int'(a_q) >= N_ACTIONS);

  assign boot = TW'(mq_q) - TW'(mq_q >> GAMMA_SHIFT);
`ifdef QUPD_TERMINAL_EN
  assign tgt = term_q ? TW'(r_q) : TW'(r_q) + boot;
`else
  assign tgt = TW'(r_q) + boot;
`endif

  // Floor-shift of delta, then widen by one bit so the sum cannot wrap.
  assign dsh  = dlt_q >>> ALPHA_SHIFT;
  assign qsum = {dsh[TW-1], dsh} +
                signed'({{(TW+1-Q_W){1'b0}}, qold_q});

  always_comb begin
    q_new = qsum[Q_W-1:0];
    if (qsum[TW])
      q_new = '0;
    else if (|qsum[TW-1:Q_W])
      q_new = '1;
  end

  always_comb begin
    st_d   = st_q;
    s_d    = s_q;
    a_d    = a_q;
    r_d    = r_q;
    mq_d   = mq_q;
    qold_d = qold_q;
    bad_d  = bad_q;
    dlt_d  = dlt_q;
    tbl_d  = tbl_q;
    done_d = 1'b0;
    err_d  = 1'b0;
`ifdef QUPD_TERMINAL_EN
    term_d = term_q;
`endif
    unique case (st_q)
      IDLE: begin
        if (bus.start) begin
          s_d  = bus.prev_state;
          a_d  = bus.prev_action;
          r_d  = bus.reward;
          mq_d = bus.max_Q;
`ifdef QUPD_TERMINAL_EN
          term_d = bus.is_terminal;
`endif
          st_d = LOAD;
        end
      end
      LOAD: begin
        bad_d  = bad_idx;
        qold_d = bad_idx ? '0 : tbl_q[si][ai];
        st_d   = CALC;
      end
      CALC: begin
        dlt_d = signed'(tgt - TW'(qold_q));
        st_d  = WRITE;
      end
      WRITE: begin
        if (!bad_q)
          tbl_d[si][ai] = q_new;
        done_d = 1'b1;
        err_d  = bad_q;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      s_q    <= '0;
      a_q    <= '0;
      r_q    <= '0;
      mq_q   <= '0;
      qold_q <= '0;
      bad_q  <= 1'b0;
      dlt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      tbl_q  <= '{default: '0};
`ifdef QUPD_TERMINAL_EN
      term_q <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      s_q    <= s_d;
      a_q    <= a_d;
      r_q    <= r_d;
      mq_q   <= mq_d;
      qold_q <= qold_d;
      bad_q  <= bad_d;
      dlt_q  <= dlt_d;
      done_q <= done_d;
      err_q  <= err_d;
      tbl_q  <= tbl_d;
`ifdef QUPD_TERMINAL_EN
      term_q <= term_d;
`endif
    end
  end

  assign bus.busy    = (st_q != IDLE);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.q_table = tbl_q;

endmodule
